// File: rtl/gen_pkg.sv
// gen_pkg: shared FSM encoding and slot-slicing helper for the mux/demux bank family
package gen_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int slot_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/gen_decoder.sv
// gen_decoder: SEL-bit index to 2^SEL one-hot, all-zero when en is low
module gen_decoder #(
    parameter int SEL = 5
) (
    input  logic              en,
    input  logic [SEL-1:0]    sel,
    output logic [2**SEL-1:0] onehot
);

    for (genvar k = 0; k < 2**SEL; k++) begin : g_bit
        assign onehot[k] = en && (sel == SEL'(k));
    end

endmodule

// File: rtl/gen_demux_bank.sv
// gen_demux_bank: write-side slot bank with valid/ready writes and a one-slot-per-cycle sweep clear
// data_out is laid out so the read mux can slice slot k at [k*BUS_WIDTH +: BUS_WIDTH].
module gen_demux_bank
    import gen_pkg::*;
#(
    parameter int BUS_WIDTH  = 4,
    parameter int SEL        = 5,
    parameter bit ZERO_SLOT0 = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [SEL-1:0]                ctrl_sel,
    input  logic [BUS_WIDTH-1:0]          data_in,
    input  logic                          clr_req,
    output logic                          busy,
    output logic [2**SEL-1:0]             slot_vld,
    output logic [BUS_WIDTH*(2**SEL)-1:0] data_out
);

    localparam int N = 2**SEL;

    state_t         state, state_nx;
    logic [SEL-1:0] cnt, cnt_nx;
    logic           accept;
    logic [N-1:0]   wr_en, clr_en;

    assign busy     = (state == ST_CLEAR);
    assign wr_ready = !busy;
    assign accept   = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // clr_req is only looked at in IDLE, so a request mid-sweep never restarts it
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == ST_IDLE) begin
            state_nx = clr_req ? ST_CLEAR : ST_IDLE;
            cnt_nx   = '0;
        end else begin
            state_nx = (cnt == '1) ? ST_IDLE : ST_CLEAR;
            cnt_nx   = cnt + 1'b1;
        end
    end

    gen_decoder #(.SEL(SEL)) u_wr_dec (
        .en     (accept),
        .sel    (ctrl_sel),
        .onehot (wr_en)
    );

    gen_decoder #(.SEL(SEL)) u_clr_dec (
        .en     (busy),
        .sel    (cnt),
        .onehot (clr_en)
    );

    for (genvar k = 0; k < N; k++) begin : g_slot
        localparam bit HARD_ZERO = ZERO_SLOT0 && (k == 0);
        logic [BUS_WIDTH-1:0] q;
        logic                 v;
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
                v <= 1'b0;
            end else if (wr_en[k] || clr_en[k]) begin
                q <= clr_en[k] ? '0 : data_in;
                v <= !clr_en[k];
            end
        end
        // a hardwired-zero slot still handshakes; its register is simply never observed
        assign data_out[slot_lsb(k, BUS_WIDTH) +: BUS_WIDTH] = HARD_ZERO ? '0 : q;
        assign slot_vld[k] = HARD_ZERO ? 1'b0 : v;
    end

endmodule
